// File: rtl/mips_wb_queue.sv
// Writeback queue ahead of mips_regfile: merges mem/alu register writes into an
// in-order FIFO, drains one write per cycle, and flags reads of still-queued registers.

// Per-entry snoop: compares one stored destination against both read ports.
module mips_wb_entry_snoop (
    input  logic       live,
    input  logic [4:0] entry_regnum,
    input  logic [4:0] rd1_regnum,
    input  logic [4:0] rd2_regnum,
    output logic       hit1,
    output logic       hit2
);
    assign hit1 = live && (entry_regnum == rd1_regnum);
    assign hit2 = live && (entry_regnum == rd2_regnum);
endmodule

module mips_wb_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_valid,
    output logic             mem_ready,
    input  logic [4:0]       mem_regnum,
    input  logic [31:0]      mem_data,
    input  logic             alu_valid,
    output logic             alu_ready,
    input  logic [4:0]       alu_regnum,
    input  logic [31:0]      alu_data,
    output logic             wr_enable,
    output logic [4:0]       wr_regnum,
    output logic [31:0]      wr_data,
    input  logic [4:0]       rd1_regnum,
    input  logic [4:0]       rd2_regnum,
    output logic             rd1_pending,
    output logic             rd2_pending,
    output logic [PTR_W:0]   count
);
    typedef struct packed {
        logic [4:0]  regnum;
        logic [31:0] data;
    } wb_entry_t;

    wb_entry_t [DEPTH-1:0] entries;
    logic [PTR_W-1:0]      head, tail, alu_slot;
    logic [PTR_W:0]        count_q, count_next;
    logic                  mem_push, alu_push, pop;
    logic [DEPTH-1:0]      hit1, hit2;

    // Ready is conservative: the same-cycle pop earns no credit, so neither
    // ready path depends on the write port or on its own valid.
    assign mem_ready = count_q < (PTR_W+1)'(DEPTH);
    assign alu_ready = ({1'b0, count_q} + (PTR_W+2)'(mem_valid)) < (PTR_W+2)'(DEPTH);

    // Writes to $0 complete the handshake but never occupy a slot.
    assign mem_push = mem_valid && mem_ready && (mem_regnum != 5'd0);
    assign alu_push = alu_valid && alu_ready && (alu_regnum != 5'd0);
    assign alu_slot = tail + PTR_W'(mem_push);

    assign pop        = (count_q != '0);
    assign count_next = count_q + (PTR_W+1)'(mem_push) + (PTR_W+1)'(alu_push)
                        - (PTR_W+1)'(pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            head    <= head + PTR_W'(pop);
            tail    <= tail + PTR_W'(mem_push) + PTR_W'(alu_push);
            count_q <= count_next;
        end
    end

    // Storage is deliberately left uninitialised; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (mem_push) entries[tail]     <= '{regnum: mem_regnum, data: mem_data};
        if (alu_push) entries[alu_slot] <= '{regnum: alu_regnum, data: alu_data};
    end

    assign wr_enable = pop;
    assign wr_regnum = pop ? entries[head].regnum : 5'd0;
    assign wr_data   = pop ? entries[head].data   : 32'd0;
    assign count     = count_q;

    // An entry is live when its distance from head (mod DEPTH) is below count;
    // the head entry stays live during the cycle it is being written.
    genvar i;
    generate
        for (i = 0; i < DEPTH; i++) begin : g_snoop
            logic [PTR_W-1:0] offset;
            logic             live;
            assign offset = PTR_W'(i) - head;
            assign live   = {1'b0, offset} < count_q;
            mips_wb_entry_snoop u_snoop (
                .live         (live),
                .entry_regnum (entries[i].regnum),
                .rd1_regnum   (rd1_regnum),
                .rd2_regnum   (rd2_regnum),
                .hit1         (hit1[i]),
                .hit2         (hit2[i])
            );
        end
    endgenerate

    assign rd1_pending = (rd1_regnum != 5'd0) && (|hit1);
    assign rd2_pending = (rd2_regnum != 5'd0) && (|hit2);
endmodule

// File: tb/tb_mips_wb_queue.sv
// Self-checking bench for mips_wb_queue: directed scenarios plus random traffic
// compared against a queue-based reference model and a shadow register file.
module tb_mips_wb_queue;
    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic        clk = 1'b0, reset = 1'b0;
    logic        mem_valid = 1'b0, alu_valid = 1'b0;
    logic        mem_ready, alu_ready, wr_enable, rd1_pending, rd2_pending;
    logic [4:0]  mem_regnum = '0, alu_regnum = '0, rd1_regnum = '0, rd2_regnum = '0, wr_regnum;
    logic [31:0] mem_data = '0, alu_data = '0, wr_data;
    logic [PTR_W:0] count;

    mips_wb_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .reset(reset),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_regnum(mem_regnum), .mem_data(mem_data),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_regnum(alu_regnum), .alu_data(alu_data),
        .wr_enable(wr_enable), .wr_regnum(wr_regnum), .wr_data(wr_data),
        .rd1_regnum(rd1_regnum), .rd2_regnum(rd2_regnum),
        .rd1_pending(rd1_pending), .rd2_pending(rd2_pending), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    ent_t        q[$];          // reference: pending writes in acceptance order
    logic [31:0] model_rf[32];
    logic [31:0] dut_rf[32];    // built from what the DUT actually drives to the regfile
    logic [4:0]  dut_log[$];
    int          n_checks = 0, n_fail = 0;

    function automatic logic exp_pending(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        foreach (q[i]) if (q[i].r == r) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive(input logic mv, input logic [4:0] mr, input logic [31:0] md,
                         input logic av, input logic [4:0] ar, input logic [31:0] ad,
                         input logic [4:0] r1, input logic [4:0] r2);
        @(negedge clk);
        mem_valid = mv; mem_regnum = mr; mem_data = md;
        alu_valid = av; alu_regnum = ar; alu_data = ad;
        rd1_regnum = r1; rd2_regnum = r2;
        #1;
    endtask

    // Advance one edge: capture the DUT's write, then apply the spec rules to the model.
    task automatic tick();
        logic am, aa;
        if (wr_enable) begin
            dut_rf[wr_regnum] = wr_data;
            dut_log.push_back(wr_regnum);
        end
        am = mem_valid && (q.size() < DEPTH);
        aa = alu_valid && ((q.size() + int'(mem_valid)) < DEPTH);
        if (q.size() != 0) begin
            model_rf[q[0].r] = q[0].d;
            void'(q.pop_front());
        end
        if (am && mem_regnum != 5'd0) q.push_back('{mem_regnum, mem_data});
        if (aa && alu_regnum != 5'd0) q.push_back('{alu_regnum, alu_data});
        @(posedge clk);
    endtask

    task automatic test_reset();
        #1;
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_checks++; if (wr_enable !== 1'b0 || wr_regnum !== 5'd0 || wr_data !== 32'd0) begin n_fail++; $display("FAIL reset_wr: got en=%0b reg=%0d data=%0h expected 0/0/0", wr_enable, wr_regnum, wr_data); end
        n_checks++; if (mem_ready !== 1'b1 || alu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b%0b expected 11", mem_ready, alu_ready); end
        n_checks++; if (rd1_pending !== 1'b0 || rd2_pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending: got %0b%0b expected 00", rd1_pending, rd2_pending); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_single_write();
        drive(1, 5'd2, 32'd88, 0, 0, 0, 5'd2, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 5'd2, 0);
        n_checks++; if (wr_enable !== 1'b1 || wr_regnum !== 5'd2 || wr_data !== 32'd88) begin n_fail++; $display("FAIL single_wr: got en=%0b reg=%0d data=%0d expected 1/2/88", wr_enable, wr_regnum, wr_data); end
        n_checks++; if (rd1_pending !== 1'b1 || count !== 3'd1) begin n_fail++; $display("FAIL single_pending: got pend=%0b count=%0d expected 1/1", rd1_pending, count); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 5'd2, 0);
        n_checks++; if (wr_enable !== 1'b0 || count !== 3'd0) begin n_fail++; $display("FAIL single_drain: got en=%0b count=%0d expected 0/0", wr_enable, count); end
        n_checks++; if (dut_rf[2] !== 32'd88) begin n_fail++; $display("FAIL single_rf: got %0d expected 88", dut_rf[2]); end
    endtask

    task automatic test_same_reg();
        logic [31:0] exp_d[2] = '{32'hF, 32'hD};
        drive(1, 5'd1, 32'hF, 1, 5'd1, 32'hD, 5'd1, 0);
        tick();
        for (int k = 0; k < 2; k++) begin
            drive(0, 0, 0, 0, 0, 0, 5'd1, 0);
            n_checks++; if (count !== 3'(2 - k)) begin n_fail++; $display("FAIL same_count%0d: got %0d expected %0d", k, count, 2 - k); end
            n_checks++; if (wr_enable !== 1'b1 || wr_regnum !== 5'd1 || wr_data !== exp_d[k]) begin n_fail++; $display("FAIL same_wr%0d: got en=%0b reg=%0d data=%0h expected 1/1/%0h", k, wr_enable, wr_regnum, wr_data, exp_d[k]); end
            n_checks++; if (rd1_pending !== 1'b1) begin n_fail++; $display("FAIL same_pending%0d: got %0b expected 1", k, rd1_pending); end
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 5'd1, 0);
        n_checks++; if (rd1_pending !== 1'b0 || wr_enable !== 1'b0) begin n_fail++; $display("FAIL same_after: got pend=%0b en=%0b expected 0/0", rd1_pending, wr_enable); end
        n_checks++; if (dut_rf[1] !== 32'hD) begin n_fail++; $display("FAIL same_rf: got %0h expected d", dut_rf[1]); end
    endtask

    task automatic test_zero_reg();
        drive(0, 0, 0, 1, 5'd0, 32'd5, 5'd0, 0);
        n_checks++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL zero_ready: got %0b expected 1", alu_ready); end
        tick();
        for (int k = 0; k < 2; k++) begin
            drive(0, 0, 0, 0, 0, 0, 5'd0, 0);
            n_checks++; if (count !== 3'd0 || wr_enable !== 1'b0 || rd1_pending !== 1'b0) begin n_fail++; $display("FAIL zero_state%0d: got count=%0d en=%0b pend=%0b expected 0/0/0", k, count, wr_enable, rd1_pending); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int idx = 0;
        int exp_cnt[5] = '{0, 2, 3, 3, 3};
        logic mv, av, am, aa;
        dut_log.delete();
        for (int cyc = 0; cyc < 40 && (idx < 12 || q.size() != 0); cyc++) begin
            mv = (idx < 12);
            av = (idx + 1 < 12);
            drive(mv, 5'(idx + 1), 32'((idx + 1) * 32'h111), av, 5'(idx + 2), 32'((idx + 2) * 32'h111), 0, 0);
            if (cyc < 5) begin
                n_checks++; if (count !== 3'(exp_cnt[cyc])) begin n_fail++; $display("FAIL b2b_count%0d: got %0d expected %0d", cyc, count, exp_cnt[cyc]); end
            end
            n_checks++; if (alu_ready !== ((q.size() + int'(mv)) < DEPTH)) begin n_fail++; $display("FAIL b2b_alu_ready%0d: got %0b with count %0d", cyc, alu_ready, q.size()); end
            am = mv && (q.size() < DEPTH);
            aa = av && ((q.size() + int'(mv)) < DEPTH);
            tick();
            idx += int'(am) + int'(aa);
        end
        n_checks++; if (dut_log.size() != 12) begin n_fail++; $display("FAIL b2b_len: got %0d expected 12", dut_log.size()); end
        foreach (dut_log[i]) begin
            n_checks++; if (dut_log[i] !== 5'(i + 1)) begin n_fail++; $display("FAIL b2b_order%0d: got %0d expected %0d", i, dut_log[i], i + 1); end
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        n_checks++; if (dut_rf[12] !== 32'hCCC || dut_rf[7] !== 32'h777) begin n_fail++; $display("FAIL b2b_rf: got %0h/%0h expected ccc/777", dut_rf[12], dut_rf[7]); end
    endtask

    task automatic test_reset_midop();
        drive(1, 5'd21, 32'hA1, 1, 5'd22, 32'hA2, 0, 0);
        tick();
        drive(1, 5'd23, 32'hA3, 1, 5'd24, 32'hA4, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 5'd23, 5'd24);
        n_checks++; if (count !== 3'd3 || rd1_pending !== 1'b1 || rd2_pending !== 1'b1) begin n_fail++; $display("FAIL midrst_pre: got count=%0d pend=%0b%0b expected 3/11", count, rd1_pending, rd2_pending); end
        reset = 1'b0;
        #1;
        n_checks++; if (count !== 3'd0 || wr_enable !== 1'b0) begin n_fail++; $display("FAIL midrst_clear: got count=%0d en=%0b expected 0/0", count, wr_enable); end
        n_checks++; if (rd1_pending !== 1'b0 || rd2_pending !== 1'b0 || mem_ready !== 1'b1 || alu_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_flags: got pend=%0b%0b rdy=%0b%0b expected 00/11", rd1_pending, rd2_pending, mem_ready, alu_ready); end
        q.delete();
        @(negedge clk);
        reset = 1'b1;
        drive(0, 0, 0, 1, 5'd9, 32'h99, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        n_checks++; if (wr_enable !== 1'b1 || wr_regnum !== 5'd9 || wr_data !== 32'h99 || count !== 3'd1) begin n_fail++; $display("FAIL midrst_after: got en=%0b reg=%0d data=%0h count=%0d expected 1/9/99/1", wr_enable, wr_regnum, wr_data, count); end
        tick();
        n_checks++; if (dut_rf[23] === 32'hA3 || dut_rf[24] === 32'hA4) begin n_fail++; $display("FAIL midrst_leak: got %0h/%0h written after reset", dut_rf[23], dut_rf[24]); end
    endtask

    task automatic test_random();
        logic ewe;
        logic [4:0] er;
        logic [31:0] ed;
        for (int cyc = 0; cyc < 300; cyc++) begin
            drive(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom(),
                  ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom(),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            ewe = (q.size() != 0);
            er  = ewe ? q[0].r : 5'd0;
            ed  = ewe ? q[0].d : 32'd0;
            n_checks++; if (count !== 3'(q.size())) begin n_fail++; $display("FAIL rnd_count%0d: got %0d expected %0d", cyc, count, q.size()); end
            n_checks++; if (mem_ready !== (q.size() < DEPTH) || alu_ready !== ((q.size() + int'(mem_valid)) < DEPTH)) begin n_fail++; $display("FAIL rnd_ready%0d: got %0b%0b with %0d queued", cyc, mem_ready, alu_ready, q.size()); end
            n_checks++; if (wr_enable !== ewe || wr_regnum !== er || wr_data !== ed) begin n_fail++; $display("FAIL rnd_wr%0d: got %0b/%0d/%0h expected %0b/%0d/%0h", cyc, wr_enable, wr_regnum, wr_data, ewe, er, ed); end
            n_checks++; if (rd1_pending !== exp_pending(rd1_regnum) || rd2_pending !== exp_pending(rd2_regnum)) begin n_fail++; $display("FAIL rnd_pending%0d: got %0b%0b expected %0b%0b", cyc, rd1_pending, rd2_pending, exp_pending(rd1_regnum), exp_pending(rd2_regnum)); end
            tick();
        end
        for (int k = 0; k < 8; k++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0);
            tick();
        end
        for (int r = 1; r < 8; r++) begin
            n_checks++; if (dut_rf[r] !== model_rf[r]) begin n_fail++; $display("FAIL rnd_rf%0d: got %0h expected %0h", r, dut_rf[r], model_rf[r]); end
        end
    endtask

    initial begin
        for (int r = 0; r < 32; r++) begin
            model_rf[r] = '0;
            dut_rf[r]   = '0;
        end
        test_reset();
        test_single_write();
        test_same_reg();
        test_zero_reg();
        test_back_to_back();
        test_reset_midop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mips_wb_queue.md
Name: mips_wb_queue

Overview:
- Writeback stage directly upstream of mips_regfile.
- Accepts register-write requests from two producers, memory-load return (mem) and ALU result (alu), buffers them in a small in-order FIFO, and drives the regfile's single write port at one write per cycle.
- Also snoops the regfile read-port register numbers and flags reads whose register still has a queued, unwritten value (hazard/stall input to decode).

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- PTR_W, 2, log2(DEPTH); pointer width.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- mem_valid  input  1  mem producer has a write request.
- mem_ready  output  1  mem request accepted this cycle when valid && ready.
- mem_regnum  input  5  mem destination register.
- mem_data  input  32  mem write data.
- alu_valid  input  1  alu producer has a write request.
- alu_ready  output  1  alu request accepted this cycle when valid && ready.
- alu_regnum  input  5  alu destination register.
- alu_data  input  32  alu write data.
- wr_enable  output  1  to regfile enable.
- wr_regnum  output  5  to regfile wr_regnum.
- wr_data  output  32  to regfile wr_data.
- rd1_regnum  input  5  snooped regfile read port 1 register number.
- rd2_regnum  input  5  snooped regfile read port 2 register number.
- rd1_pending  output  1  rd1_regnum has a queued write.
- rd2_pending  output  1  rd2_regnum has a queued write.
- count  output  PTR_W+1  number of valid entries.

Behaviour:
- Storage: circular FIFO of {regnum[4:0], data[31:0]}; head/tail pointers wrap modulo DEPTH; count register holds 0..DEPTH.
- Reset: while reset==0, asynchronously clear head, tail and count.
  - Consequences: wr_enable=0, wr_regnum=0, wr_data=0, rd1_pending=0, rd2_pending=0, count=0, mem_ready=1, alu_ready=1.
  - Entry storage is not cleared.
  - Reset mid-operation discards all queued writes with no partial regfile write.
- Ready (combinational, conservative, no credit for the same-cycle pop):
  - mem_ready = (count < DEPTH).
  - alu_ready = (count + mem_valid) < DEPTH.
  - Neither ready depends on its own valid.
- Enqueue at posedge:
  - mem is accepted first (older instruction), then alu; up to 2 entries per cycle.
  - When both are accepted, mem goes to tail and alu to tail+1.
- $0 filter: an accepted request with regnum==0 completes its handshake but is not enqueued and consumes no entry. When mem is dropped, the alu entry goes to tail.
- Same regnum from both producers in one cycle: both are enqueued; the regfile sees the mem write then the alu write, so the alu value wins.
- Dequeue:
  - wr_enable = (count != 0), combinational.
  - wr_regnum/wr_data = head entry when count != 0, else 0.
  - Head pops at every posedge where count != 0; the regfile write happens on that same edge.
- Latency: a request accepted at edge N is written to the regfile no earlier than edge N+1, and exactly N+1 when the queue was empty and it is the first accepted entry.
- count update: count_next = count + accepted_nonzero - (count != 0). It never exceeds DEPTH and never underflows.
- Pending (combinational):
  - rdX_pending = 1 iff rdX_regnum != 0 and any valid entry (head .. head+count-1) has regnum == rdX_regnum.
  - The head entry counts as pending in the cycle it is being written.
  - Requests being offered but not yet accepted are not pending.
- Ordering: regfile writes occur in strict acceptance order; no entry is lost or duplicated; pointers wrap at DEPTH-1 -> 0.

Test Plan:
- Reset low 10 units, release, then mem_valid=1, regnum=2, data=88 for one cycle -> next cycle wr_enable=1, wr_regnum=2, wr_data=88; the following cycle wr_enable=0, count=0; the regfile then reads 88 on reg 2.
- Same cycle: mem reg1=0xF and alu reg1=0xD -> count=2; consecutive writes 0xF then 0xD; rd1_regnum=1 gives rd1_pending=1 for both write cycles and 0 after; the regfile reads 0xD.
- alu_valid with regnum=0, data=5 -> alu_ready=1, count stays 0, wr_enable never asserts, rd1_pending=0 with rd1_regnum=0.
- Both producers valid every cycle with distinct regs 1..12 -> count rises 2, 3, then holds 3; alu_ready=0 whenever count==3 && mem_valid; writes occur in mem-before-alu acceptance order across pointer wrap, with no loss.
- With 3 entries queued, drive reset=0 between clock edges -> count=0, wr_enable=0, pending=0 immediately (before the next edge); after release, new writes behave normally.
